imem_loader: RTL and testbench

Boot-time program loader: the write side of the instruction memory that the fetch stage reads. It takes a byte stream from the UART receiver, assembles little-endian 32-bit instruction words and writes them sequentially into the instruction memory write port starting at word address 0. While loading, it holds the CPU in reset so that fetch never observes a partially written image.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_timeout.sv | 30 +++
 rtl/imem_loader.sv | 215 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time program loader.
//   state_e    - loader FSM states (S_CSUM only reachable with IMEM_LOADER_CHECKSUM_EN)
//   lane_t     - byte-lane index within a 32-bit little-endian word
//   LEN_BYTES  - bytes in the frame length field
//   CSUM_BYTES - bytes in the trailing checksum field
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam int LEN_BYTES  = 4;
  localparam int CSUM_BYTES = 4;

  typedef logic [1:0] lane_t;

  // States in which the loader owns the memory and holds the CPU in reset.
  function automatic logic is_busy(input state_e s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// imem_loader_timeout: idle-cycle counter with a saturating timeout flag.
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   i_clr     - clear the counter (byte accepted, or loader not busy)
//   o_timeout - high once TIMEOUT_CYCLES idle cycles have elapsed since the last clear
module imem_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_timeout
);

  localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  ONE   = CW'(1);

  logic [CW-1:0] r_cnt;

  // Saturates at LIMIT so the flag stays up until something clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_cnt <= '0;
    else if (i_clr)          r_cnt <= '0;
    else if (r_cnt != LIMIT) r_cnt <= r_cnt + ONE;
  end

  assign o_timeout = (r_cnt == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader feeding the instruction memory write port.
// Receives a UART byte stream framed as a 4-byte little-endian word count N followed
// by N little-endian 32-bit words, and writes them to word addresses 0..N-1 while
// holding the CPU in reset.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing 4-byte
// little-endian checksum (32-bit wrapping sum of N and all words) before DONE.
//
// Ports:
//   clk, rst       - system clock, asynchronous active-low reset
//   start          - single-cycle load request (ignored while busy)
//   rx_valid/data  - received byte strobe and value
//   we/addr/wdata  - instruction memory write port, one cycle per word
//   busy, cpu_hold - high while a frame is being received
//   done, error    - frame completed / frame aborted (length, timeout, checksum)
//   words_written  - words written during the current load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_written
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [32:0]   MAX_WORDS = 33'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);
  // With the checksum, a zero-length frame or the last word lead into CSUM.
  localparam state_e        FIN_STATE = CSUM_EN ? S_CSUM : S_DONE;

  state_e            r_state, w_state_nxt;
  lane_t             r_bidx;
  logic [23:0]       r_asm;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_words;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_busy;
  logic              w_start_ok;
  logic              w_acc;
  logic              w_byte_last;
  lane_t             w_last_idx;
  logic [31:0]       w_word;
  logic              w_len_zero;
  logic              w_len_big;
  logic              w_word_last;
  logic              w_data_fin;
  logic              w_sum_ok;
  logic              w_tmo_clr;
  logic              w_tmo_flag;
  logic              w_timeout;

  assign w_busy     = is_busy(r_state);
  assign w_start_ok = start && !w_busy;

  // Without the checksum, DATA lingers one cycle so DONE follows the final write.
  assign w_data_fin = r_we && (r_words == r_len);

  // A timeout wins over a simultaneous byte so nothing is written on the way to ERR.
  assign w_acc = rx_valid && w_busy && !w_timeout &&
                 !((r_state == S_DATA) && w_data_fin);

  always_comb begin
    w_last_idx = lane_t'(3);
    unique case (r_state)
      S_LEN:   w_last_idx = lane_t'(LEN_BYTES - 1);
      S_CSUM:  w_last_idx = lane_t'(CSUM_BYTES - 1);
      default: w_last_idx = lane_t'(3);
    endcase
  end

  assign w_byte_last = (r_bidx == w_last_idx);
  assign w_word      = {rx_data, r_asm};
  assign w_len_zero  = (w_word == 32'd0);
  assign w_len_big   = ({1'b0, w_word} > MAX_WORDS);
  assign w_word_last = ((r_words + ONE_W) == r_len);

  assign w_tmo_clr = w_acc || !w_busy;
  assign w_timeout = w_busy && w_tmo_flag;

  imem_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmo_clr),
    .o_timeout (w_tmo_flag)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        if (w_timeout)                  w_state_nxt = S_ERR;
        else if (w_acc && w_byte_last) begin
          if (w_len_big)                w_state_nxt = S_ERR;
          else if (w_len_zero)          w_state_nxt = FIN_STATE;
          else                          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_timeout)                  w_state_nxt = S_ERR;
        else if (CSUM_EN && w_acc && w_byte_last && w_word_last)
                                        w_state_nxt = S_CSUM;
        else if (!CSUM_EN && w_data_fin) w_state_nxt = S_DONE;
      end
      S_CSUM: begin
        if (w_timeout)                  w_state_nxt = S_ERR;
        else if (w_acc && w_byte_last)  w_state_nxt = w_sum_ok ? S_DONE : S_ERR;
      end
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy     = w_busy;
    cpu_hold = w_busy;
    done     = (r_state == S_DONE);
    error    = (r_state == S_ERR);
  end

  assign we            = r_we;
  assign addr          = r_addr;
  assign wdata         = r_wdata;
  assign words_written = r_words;

  // ---------------------------------------------------------------- datapath
  // Bytes 0..2 of every 4-byte field land in their lane of r_asm; the 4th byte
  // completes the field combinationally in w_word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bidx  <= '0;
      r_asm   <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_bidx  <= '0;
        r_words <= '0;
        r_addr  <= '0;
      end else if (w_acc) begin
        r_bidx <= w_byte_last ? lane_t'(0) : r_bidx + lane_t'(1);
        case (r_bidx)
          2'd0:    r_asm[7:0]   <= rx_data;
          2'd1:    r_asm[15:8]  <= rx_data;
          2'd2:    r_asm[23:16] <= rx_data;
          default: ;
        endcase
        if (w_byte_last) begin
          if (r_state == S_LEN) r_len <= w_word[ADDR_W:0];
          if (r_state == S_DATA) begin
            r_we    <= 1'b1;
            r_addr  <= r_words[ADDR_W-1:0];
            r_wdata <= w_word;
            r_words <= r_words + ONE_W;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- checksum
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_acc && w_byte_last) begin
      if (r_state == S_LEN)       r_sum <= w_word;
      else if (r_state == S_DATA) r_sum <= r_sum + w_word;
    end
  end

  assign w_sum_ok = (w_word == r_sum);
`else
  assign w_sum_ok = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW    = 4;
  localparam int TO    = 40;
  localparam int DEPTH = 1 << AW;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          busy, done, error, cpu_hold;
  logic [AW:0]   words_written;

  imem_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .we(we), .addr(addr), .wdata(wdata), .busy(busy), .done(done), .error(error),
    .cpu_hold(cpu_hold), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log: every memory write seen, with its cycle and the CPU hold level.
  int          wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  bit          wh_q[$];
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(int'(addr));
      wd_q.push_back(wdata);
      wc_q.push_back(cyc);
      wh_q.push_back(cpu_hold);
    end
  end

  logic [31:0] fw[$];        // words of the frame to send
  int          word_cyc[$];  // cycle at which each word's 4th byte was taken

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); wh_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  // Sends start + frame (length, fw words, checksum when enabled and the frame is
  // well formed), stopping before byte stall_at; then waits for done or error.
  // gap < 0 picks a random 0..3 idle gap per byte.
  task automatic run_frame(input logic [31:0] n, input int gap, input int stall_at,
                           input logic [31:0] csum_xor, output int done_cyc,
                           output int last_cyc, output bit ended, output bit busy_seen);
    logic [7:0]  bq[$];
    logic [31:0] sum;
    sum = n;
    for (int k = 0; k < 4; k++) bq.push_back(n[8*k +: 8]);
    foreach (fw[i]) begin
      for (int k = 0; k < 4; k++) bq.push_back(fw[i][8*k +: 8]);
      sum = sum + fw[i];
    end
    if (CSUM_EN && n <= 32'(DEPTH) && fw.size() == int'(n)) begin
      sum = sum ^ csum_xor;
      for (int k = 0; k < 4; k++) bq.push_back(sum[8*k +: 8]);
    end
    word_cyc.delete();
    start = 1'b1; tick(); start = 1'b0;
    busy_seen = busy && cpu_hold;
    last_cyc = cyc;
    foreach (bq[i]) begin
      if (i == stall_at) break;
      send_byte(bq[i], (gap < 0) ? int'($urandom_range(3, 0)) : gap);
      last_cyc = cyc;
      if (i >= 4 && i < 4 + 4*fw.size() && (i % 4) == 3) word_cyc.push_back(cyc);
    end
    ended = 1'b0; done_cyc = -1;
    for (int t = 0; t < 4*TO + 50 && !ended; t++) begin
      if (done || error) begin ended = 1'b1; done_cyc = cyc; end
      else tick();
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    #2 rst = 1'b0;
    tick(); tick();
    vectors++; if ({we, busy, done, error, cpu_hold} !== 5'b0) begin miscompares++;
      $display("FAIL reset_flags: got we/busy/done/err/hold=%b want 00000", {we, busy, done, error, cpu_hold}); end
    vectors++; if (addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %0h want 0", addr); end
    vectors++; if (wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    vectors++; if (words_written !== '0) begin miscompares++; $display("FAIL reset_words: got %0d want 0", words_written); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int dc, lc; bit ended, bs;
    fw = '{32'h00500093, 32'h00A00113};
    clear_log();
    run_frame(32'd2, 0, -1, 32'h0, dc, lc, ended, bs);
    vectors++; if (!ended) begin miscompares++; $display("FAIL basic_end: got no done/error want done"); end
    vectors++; if (bs !== 1'b1) begin miscompares++; $display("FAIL basic_busy_after_start: got %0b want 1", bs); end
    vectors++; if (wa_q.size() != 2) begin miscompares++; $display("FAIL basic_nwrites: got %0d want 2", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 2; i++) begin
      vectors++;
      if (wa_q[i] != i || wd_q[i] !== fw[i] || wc_q[i] != word_cyc[i] || wh_q[i] !== 1'b1) begin miscompares++;
        $display("FAIL basic_write[%0d]: got addr=%0d data=%h cyc=%0d hold=%0b want addr=%0d data=%h cyc=%0d hold=1",
                 i, wa_q[i], wd_q[i], wc_q[i], wh_q[i], i, fw[i], word_cyc[i]); end
    end
    vectors++; if (wc_q.size() == 2 && wc_q[1] - wc_q[0] != 4) begin miscompares++;
      $display("FAIL basic_b2b_spacing: got %0d want 4", wc_q[1] - wc_q[0]); end
    vectors++; if (dc != (CSUM_EN ? lc : lc + 1)) begin miscompares++;
      $display("FAIL basic_done_cycle: got %0d want %0d", dc, CSUM_EN ? lc : lc + 1); end
    vectors++; if ({done, error, busy, cpu_hold} !== 4'b1000 || words_written !== 5'd2) begin miscompares++;
      $display("FAIL basic_final: got done/err/busy/hold=%b words=%0d want 1000 words=2",
               {done, error, busy, cpu_hold}, words_written); end
  endtask

  task automatic test_random_loads();
    int dc, lc, n, gap; bit ended, bs;
    for (int it = 0; it < 6; it++) begin
      n   = (it == 0) ? DEPTH : int'($urandom_range(DEPTH, 1));
      gap = (it % 2 == 0) ? 0 : -1;
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back($urandom);
      // Bytes while not busy must be ignored.
      send_byte(8'($urandom), 0); send_byte(8'($urandom), 1);
      clear_log();
      run_frame(32'(n), gap, -1, 32'h0, dc, lc, ended, bs);
      vectors++; if (!ended || done !== 1'b1 || error !== 1'b0) begin miscompares++;
        $display("FAIL rand%0d_status: got ended=%0b done=%0b err=%0b want 1 1 0", it, ended, done, error); end
      vectors++; if (wa_q.size() != n || words_written !== (AW+1)'(n)) begin miscompares++;
        $display("FAIL rand%0d_count: got writes=%0d words=%0d want %0d", it, wa_q.size(), words_written, n); end
      for (int i = 0; i < wa_q.size() && i < n; i++) begin
        vectors++;
        if (wa_q[i] != i || wd_q[i] !== fw[i] || wc_q[i] != word_cyc[i] || wh_q[i] !== 1'b1) begin miscompares++;
          $display("FAIL rand%0d_write[%0d]: got addr=%0d data=%h cyc=%0d hold=%0b want addr=%0d data=%h cyc=%0d hold=1",
                   it, i, wa_q[i], wd_q[i], wc_q[i], wh_q[i], i, fw[i], word_cyc[i]); end
      end
      vectors++; if (dc != (CSUM_EN ? lc : lc + 1)) begin miscompares++;
        $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, dc, CSUM_EN ? lc : lc + 1); end
    end
  endtask

  task automatic test_zero_len();
    int dc, lc; bit ended, bs;
    fw.delete();
    clear_log();
    run_frame(32'd0, -1, -1, 32'h0, dc, lc, ended, bs);
    vectors++; if (!ended || done !== 1'b1 || error !== 1'b0) begin miscompares++;
      $display("FAIL zero_status: got ended=%0b done=%0b err=%0b want 1 1 0", ended, done, error); end
    vectors++; if (wa_q.size() != 0) begin miscompares++; $display("FAIL zero_nwrites: got %0d want 0", wa_q.size()); end
    vectors++; if (dc != lc) begin miscompares++; $display("FAIL zero_done_cycle: got %0d want %0d", dc, lc); end
    vectors++; if (words_written !== '0 || cpu_hold !== 1'b0) begin miscompares++;
      $display("FAIL zero_final: got words=%0d hold=%0b want 0 0", words_written, cpu_hold); end
  endtask

  task automatic test_too_long();
    int dc, lc; bit ended, bs;
    logic [31:0] lens [2];
    lens[0] = 32'(DEPTH + 1);
    lens[1] = 32'h0100_0000 | 32'(DEPTH);
    fw.delete();
    for (int k = 0; k < 2; k++) begin
      clear_log();
      run_frame(lens[k], -1, -1, 32'h0, dc, lc, ended, bs);
      vectors++; if (!ended || error !== 1'b1 || done !== 1'b0) begin miscompares++;
        $display("FAIL toolong%0d_status: got ended=%0b err=%0b done=%0b want 1 1 0", k, ended, error, done); end
      vectors++; if (dc != lc) begin miscompares++; $display("FAIL toolong%0d_err_cycle: got %0d want %0d", k, dc, lc); end
      vectors++; if (wa_q.size() != 0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin miscompares++;
        $display("FAIL toolong%0d_final: got writes=%0d busy=%0b hold=%0b want 0 0 0", k, wa_q.size(), busy, cpu_hold); end
    end
  endtask

  task automatic test_timeout();
    int dc, lc; bit ended, bs;
    // Gaps just under the limit are tolerated.
    fw = '{32'hCAFE_F00D};
    clear_log();
    run_frame(32'd1, TO - 2, -1, 32'h0, dc, lc, ended, bs);
    vectors++; if (!ended || done !== 1'b1 || wa_q.size() != 1) begin miscompares++;
      $display("FAIL slow_gap_status: got ended=%0b done=%0b writes=%0d want 1 1 1", ended, done, wa_q.size()); end
    // Stall after the 5th data byte (frame byte index 8).
    fw = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    clear_log();
    run_frame(32'd3, 0, 9, 32'h0, dc, lc, ended, bs);
    vectors++; if (!ended || error !== 1'b1 || done !== 1'b0) begin miscompares++;
      $display("FAIL timeout_status: got ended=%0b err=%0b done=%0b want 1 1 0", ended, error, done); end
    vectors++; if (dc < lc + TO - 1 || dc > lc + TO + 2) begin miscompares++;
      $display("FAIL timeout_cycle: got %0d want %0d..%0d", dc, lc + TO - 1, lc + TO + 2); end
    vectors++; if (wa_q.size() != 1 || words_written !== 5'd1) begin miscompares++;
      $display("FAIL timeout_writes: got writes=%0d words=%0d want 1 1", wa_q.size(), words_written); end
    vectors++; if (wa_q.size() > 0 && (wa_q[0] != 0 || wd_q[0] !== fw[0])) begin miscompares++;
      $display("FAIL timeout_word0: got addr=%0d data=%h want 0 %h", wa_q[0], wd_q[0], fw[0]); end
  endtask

  task automatic test_reset_midload();
    int dc, lc; bit ended, bs;
    logic [31:0] len;
    logic [31:0] w0;
    len = 32'd4;
    w0  = $urandom;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8], 0);
    for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
    send_byte(8'h5A, 0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midload_busy: got %0b want 1", busy); end
    // Land the next 4th byte then pull reset while that write is on the port.
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
    vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL midload_we_before_rst: got %0b want 1", we); end
    #2 rst = 1'b0;
    #1;
    vectors++; if ({we, busy, done, error, cpu_hold} !== 5'b0 || addr !== '0 || wdata !== 32'h0 || words_written !== '0) begin
      miscompares++;
      $display("FAIL midload_async_rst: got flags=%b addr=%0d wdata=%h words=%0d want 0 0 0 0",
               {we, busy, done, error, cpu_hold}, addr, wdata, words_written); end
    tick(); tick();
    rst = 1'b1;
    tick();
    fw = '{$urandom, $urandom};
    clear_log();
    run_frame(32'd2, -1, -1, 32'h0, dc, lc, ended, bs);
    vectors++; if (!ended || done !== 1'b1 || wa_q.size() != 2) begin miscompares++;
      $display("FAIL reload_status: got ended=%0b done=%0b writes=%0d want 1 1 2", ended, done, wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 2; i++) begin
      vectors++; if (wa_q[i] != i || wd_q[i] !== fw[i]) begin miscompares++;
        $display("FAIL reload_write[%0d]: got addr=%0d data=%h want %0d %h", i, wa_q[i], wd_q[i], i, fw[i]); end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int dc, lc; bit ended, bs;
    fw = '{32'h12345678};
    clear_log();
    run_frame(32'd1, 0, -1, 32'h0, dc, lc, ended, bs);   // sends 0x12345679
    vectors++; if (!ended || done !== 1'b1 || error !== 1'b0 || dc != lc) begin miscompares++;
      $display("FAIL csum_good: got ended=%0b done=%0b err=%0b cyc=%0d want 1 1 0 %0d", ended, done, error, dc, lc); end
    vectors++; if (wh_q.size() != 1 || wh_q[0] !== 1'b1) begin miscompares++;
      $display("FAIL csum_write: got writes=%0d want 1 with hold", wh_q.size()); end
    clear_log();
    run_frame(32'd1, 0, -1, 32'h1, dc, lc, ended, bs);   // sends 0x12345678
    vectors++; if (!ended || error !== 1'b1 || done !== 1'b0 || dc != lc) begin miscompares++;
      $display("FAIL csum_bad: got ended=%0b err=%0b done=%0b cyc=%0d want 1 1 0 %0d", ended, error, done, dc, lc); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random_loads();
    test_zero_len();
    test_too_long();
    test_timeout();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
